// File: rtl/silly_pkg.sv
// Shared definitions for the silly_function_unit slice: default truth table,
// the {a,b,c} index type and the table lookup helper.
package silly_pkg;

    // Bits 0, 4 and 5 set: y = ~b & (a | ~c)
    localparam logic [7:0] SILLY_TT_DEFAULT = 8'h31;

    typedef logic [2:0] silly_idx_t;

    function automatic logic silly_lookup(input logic [7:0] tt, input silly_idx_t idx);
        return tt[idx];
    endfunction

endpackage

// File: rtl/silly_function_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over
// increment and the count never wraps past all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;
    logic         w_at_max;

    assign w_at_max = &r_count;

    // Clear first, otherwise count up until all-ones and hold there
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/silly_function_unit.sv
// Fixed 3-input Boolean function defined by a truth table, with a registered
// copy of the result, a capture-valid flag and a saturating hit counter.
module silly_function_unit
    import silly_pkg::*;
#(
    parameter logic [7:0] TRUTH_TABLE = SILLY_TT_DEFAULT,
    parameter int         CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             en,
    input  logic             clr,
    output logic             y,
    output logic             y_q,
    output logic             valid_q,
    output logic [CNT_W-1:0] hit_count
);

    silly_idx_t w_idx;
    logic       w_y;
    logic       w_hit;
    logic       r_y_q;
    logic       r_valid_q;

    // Pure lookup; no clock, reset or enable involvement so X on inputs reaches y
    always_comb begin
        w_idx = {a, b, c};
        w_y   = silly_lookup(TRUTH_TABLE, w_idx);
    end

    assign y     = w_y;
    assign w_hit = en & w_y;

    // Capture y when enabled; valid marks the cycle following a capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_y_q     <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= en;
            if (en) begin
                r_y_q <= w_y;
            end
        end
    end

    assign y_q     = r_y_q;
    assign valid_q = r_valid_q;

    sat_counter #(
        .W (CNT_W)
    ) u_hit_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .inc     (w_hit),
        .count   (hit_count)
    );

endmodule

// File: tb/tb_silly_function_unit.sv
// Scoreboard bench for silly_function_unit: default table, 8'hA5 table and
// a 3-bit counter instance.
module tb_silly_function_unit;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
    } chk_item_t;

    typedef struct {
        string      name;
        logic       yq;
        logic [7:0] hc;
    } cap_item_t;

    localparam int SEL_Y    = 0;
    localparam int SEL_YQ   = 1;
    localparam int SEL_VQ   = 2;
    localparam int SEL_HC   = 3;
    localparam int SEL_YA5  = 4;
    localparam int SEL_HC3  = 5;
    localparam int SEL_VQ3  = 6;

    logic clk = 1'b0;
    logic clk_on = 1'b0;
    logic reset_n = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0, en = 1'b0, clr = 1'b0;
    logic a3 = 1'b0, b3 = 1'b0, c3 = 1'b0, en3 = 1'b0, clr3 = 1'b0;
    logic en_a5 = 1'b0;

    logic       y, y_q, valid_q;
    logic [7:0] hit_count;
    logic       y3, y_q3, valid_q3;
    logic [2:0] hc3;
    logic       y_a5, yq_a5, vq_a5;
    logic [7:0] hc_a5;

    int checks = 0;
    int errors = 0;

    chk_item_t chk_q[$];
    cap_item_t cap_q[$];
    cap_item_t cap3_q[$];
    event      chk_ev;

    silly_function_unit dut (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .c(c), .en(en), .clr(clr),
        .y(y), .y_q(y_q), .valid_q(valid_q), .hit_count(hit_count)
    );

    silly_function_unit #(.CNT_W(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .a(a3), .b(b3), .c(c3), .en(en3), .clr(clr3),
        .y(y3), .y_q(y_q3), .valid_q(valid_q3), .hit_count(hc3)
    );

    silly_function_unit #(.TRUTH_TABLE(8'hA5)) dut_a5 (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .c(c), .en(en_a5), .clr(clr),
        .y(y_a5), .y_q(yq_a5), .valid_q(vq_a5), .hit_count(hc_a5)
    );

    always #5 if (clk_on) clk = ~clk;

    function automatic logic [7:0] act(input int sel);
        case (sel)
            SEL_Y:   return {7'b0, y};
            SEL_YQ:  return {7'b0, y_q};
            SEL_VQ:  return {7'b0, valid_q};
            SEL_HC:  return hit_count;
            SEL_YA5: return {7'b0, y_a5};
            SEL_HC3: return {5'b0, hc3};
            SEL_VQ3: return {7'b0, valid_q3};
            default: return 8'hxx;
        endcase
    endfunction

    // Immediate-check monitor: drains the queue whenever stimulus asks for a sample
    initial begin
        forever begin
            @(chk_ev);
            while (chk_q.size() > 0) begin
                chk_item_t it;
                logic [7:0] got;
                it  = chk_q.pop_front();
                got = act(it.sel);
                checks++;
                if (got !== it.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h at %0t", it.name, got, it.exp, $time);
                end
            end
        end
    end

    // Capture monitor for the default instance, driven by valid_q
    always @(negedge clk) begin
        if (valid_q === 1'b1) begin
            checks++;
            if (cap_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: valid_q=1 with nothing expected at %0t", $time);
            end else begin
                cap_item_t it;
                it = cap_q.pop_front();
                if (y_q !== it.yq || hit_count !== it.hc) begin
                    errors++;
                    $display("FAIL %s: got y_q=%b hit_count=%0d expected y_q=%b hit_count=%0d",
                             it.name, y_q, hit_count, it.yq, it.hc);
                end
            end
        end
    end

    // Capture monitor for the 3-bit counter instance
    always @(negedge clk) begin
        if (valid_q3 === 1'b1) begin
            checks++;
            if (cap3_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid3: valid_q=1 with nothing expected at %0t", $time);
            end else begin
                cap_item_t it;
                it = cap3_q.pop_front();
                if (y_q3 !== it.yq || {5'b0, hc3} !== it.hc) begin
                    errors++;
                    $display("FAIL %s: got y_q=%b hit_count=%0d expected y_q=%b hit_count=%0d",
                             it.name, y_q3, hc3, it.yq, it.hc);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [7:0] exp);
        chk_item_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = exp;
        chk_q.push_back(it);
    endtask

    task automatic sample();
        ->chk_ev;
        #1;
    endtask

    task automatic cap(input logic [2:0] abc, input logic e, input logic cl,
                       input string name, input logic yq, input logic [7:0] hc);
        cap_item_t it;
        @(negedge clk);
        {a, b, c} = abc;
        en  = e;
        clr = cl;
        if (e) begin
            it.name = name;
            it.yq   = yq;
            it.hc   = hc;
            cap_q.push_back(it);
        end
    endtask

    // Watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach end, got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    logic [2:0] comb_abc [6] = '{3'b000, 3'b100, 3'b101, 3'b011, 3'b010, 3'b111};
    logic       comb_y   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] tt_def  = 8'h31;
    logic [7:0] tt_a5   = 8'hA5;
    logic [7:0] sat_exp [10] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd7, 8'd7, 8'd7};

    initial begin
        // Asynchronous reset with the clock stopped
        #1 reset_n = 1'b0;
        #2;
        expect_val("rst_y_q", SEL_YQ, 8'd0);
        expect_val("rst_valid_q", SEL_VQ, 8'd0);
        expect_val("rst_hit_count", SEL_HC, 8'd0);
        expect_val("rst_y_tracks", SEL_Y, 8'd1);
        sample();
        reset_n = 1'b1;
        #5;

        // Combinational path, no clock
        for (int i = 0; i < 6; i++) begin
            {a, b, c} = comb_abc[i];
            #5;
            expect_val($sformatf("comb_y_%03b", comb_abc[i]), SEL_Y, {7'b0, comb_y[i]});
            sample();
            #4;
        end

        // Exhaustive sweep against both truth tables
        for (int i = 0; i < 8; i++) begin
            {a, b, c} = 3'(i);
            #2;
            expect_val($sformatf("sweep_31_%0d", i), SEL_Y, {7'b0, tt_def[i]});
            expect_val($sformatf("sweep_a5_%0d", i), SEL_YA5, {7'b0, tt_a5[i]});
            sample();
        end

        {a, b, c} = 3'b000;
        clk_on = 1'b1;

        // Single capture then hold
        cap(3'b100, 1'b1, 1'b0, "cap_100", 1'b1, 8'd1);
        cap(3'b000, 1'b0, 1'b0, "", 1'b0, 8'd0);
        @(negedge clk);
        expect_val("hold_valid_q", SEL_VQ, 8'd0);
        expect_val("hold_y_q", SEL_YQ, 8'd1);
        expect_val("hold_hit_count", SEL_HC, 8'd1);
        sample();

        // Mixed captures, misses do not count
        cap(3'b000, 1'b1, 1'b0, "cap_000", 1'b1, 8'd2);
        cap(3'b011, 1'b1, 1'b0, "cap_011", 1'b0, 8'd2);
        cap(3'b101, 1'b1, 1'b0, "cap_101", 1'b1, 8'd3);
        cap(3'b110, 1'b1, 1'b0, "cap_110", 1'b0, 8'd3);

        // Clear wins over a simultaneous hit
        cap(3'b100, 1'b1, 1'b1, "clr_with_cap", 1'b1, 8'd0);

        // Count back up to 5
        cap(3'b000, 1'b1, 1'b0, "up_1", 1'b1, 8'd1);
        cap(3'b100, 1'b1, 1'b0, "up_2", 1'b1, 8'd2);
        cap(3'b101, 1'b1, 1'b0, "up_3", 1'b1, 8'd3);
        cap(3'b000, 1'b1, 1'b0, "up_4", 1'b1, 8'd4);
        cap(3'b100, 1'b1, 1'b0, "up_5", 1'b1, 8'd5);
        cap(3'b100, 1'b0, 1'b0, "", 1'b0, 8'd0);
        @(negedge clk);
        expect_val("pre_rst_hit_count", SEL_HC, 8'd5);
        sample();

        // Saturation on a 3-bit counter
        {a3, b3, c3} = 3'b000;
        for (int i = 0; i < 10; i++) begin
            cap_item_t it;
            @(negedge clk);
            en3 = 1'b1;
            it.name = $sformatf("sat_edge_%0d", i);
            it.yq   = 1'b1;
            it.hc   = sat_exp[i];
            cap3_q.push_back(it);
        end
        begin
            cap_item_t it;
            @(negedge clk);
            clr3 = 1'b1;
            it.name = "sat_clr_with_cap";
            it.yq   = 1'b1;
            it.hc   = 8'd0;
            cap3_q.push_back(it);
        end
        @(negedge clk);
        en3  = 1'b0;
        clr3 = 1'b0;
        @(negedge clk);
        expect_val("sat_after_clr", SEL_HC3, 8'd0);
        expect_val("sat_valid_low", SEL_VQ3, 8'd0);
        sample();
        expect_val("pre_rst_hit_count2", SEL_HC, 8'd5);
        expect_val("pre_rst_y_q", SEL_YQ, 8'd1);
        sample();

        // Mid-cycle reset pulse clears registers at once; y keeps tracking
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        expect_val("midrst_y_q", SEL_YQ, 8'd0);
        expect_val("midrst_valid_q", SEL_VQ, 8'd0);
        expect_val("midrst_hit_count", SEL_HC, 8'd0);
        sample();
        {a, b, c} = 3'b010;
        #1;
        expect_val("midrst_y_010", SEL_Y, 8'd0);
        sample();
        {a, b, c} = 3'b101;
        #1;
        expect_val("midrst_y_101", SEL_Y, 8'd1);
        sample();
        reset_n = 1'b1;

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (cap_q.size() != 0) begin
            errors++;
            $display("FAIL cap_q_drained: got %0d pending expected 0", cap_q.size());
        end
        checks++;
        if (cap3_q.size() != 0) begin
            errors++;
            $display("FAIL cap3_q_drained: got %0d pending expected 0", cap3_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/silly_function_unit.md
Name: silly_function_unit

Overview:
- Evaluates the fixed 3-input Boolean function y = ~a&~b&~c | a&~b&~c | a&~b&c, which minimises to y = ~b & (a | ~c).
- y is purely combinational and valid with no clock activity.
- Also provides a registered copy of y, a valid flag and a saturating count of true evaluations, for use as a small clocked logic-function slice in datapath experiments.
- The function is defined by a truth-table parameter; the default reproduces the function above.

Parameters:
- TRUTH_TABLE, 8'h31: bit i is the output for index i = {a,b,c}; the default sets bits 0, 4 and 5.
- CNT_W, 8: width of hit_count.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- reset_n  input  1  Asynchronous, active-low reset.
- a  input  1  Function input, MSB of the index.
- b  input  1  Function input, middle bit of the index.
- c  input  1  Function input, LSB of the index.
- en  input  1  Capture enable for the registered path.
- clr  input  1  Synchronous clear of hit_count.
- y  output  1  Combinational result, TRUTH_TABLE[{a,b,c}].
- y_q  output  1  Registered result.
- valid_q  output  1  High the cycle after a capture.
- hit_count  output  CNT_W  Count of captures where y was 1.

Behaviour:
- y = TRUTH_TABLE[{a,b,c}] at all times, with zero-delay combinational logic.
  - y has no dependence on clk, reset_n, en or clr.
  - y is correct immediately after inputs change, even if clk never toggles.
- Default truth table: 000→1, 001→0, 010→0, 011→0, 100→1, 101→1, 110→0, 111→0.
- X/Z on a, b or c propagates to y; no masking.
- Reset (reset_n low, asynchronous assert, release synchronised by the user): y_q=0, valid_q=0, hit_count=0. y is unaffected by reset.
- Each rising edge with reset_n high:
  - en=1: y_q ← y; valid_q ← 1.
  - en=0: y_q holds; valid_q ← 0.
  - Latency from input to y_q is one cycle.
- hit_count, in priority order:
  - clr=1: ← 0. Clear wins over a simultaneous capture, so that capture is not counted.
  - else en=1 and y=1 and hit_count not all-ones: ← hit_count+1.
  - at all-ones: saturates and holds; no wrap.
- Reset asserted mid-operation clears all registered outputs in the same instant, with no clock needed.

Decomposition:
- Shared package silly_pkg:
  - constant SILLY_TT_DEFAULT = 8'h31
  - typedef logic [2:0] silly_idx_t for the {a,b,c} index
- One sub-module is natural: sat_counter (parameter W; inputs clk, reset_n, clr, inc; output count), instantiated for hit_count.
- The lookup and the y_q/valid_q registers stay in the top module.

Test Plan:
- No clock, reset_n=1. Apply abc=000, 100, 101, 011, 010, 111, holding each for 10 time units → y=1, 1, 1, 0, 0, 0.
- Exhaustive sweep of all 8 abc values → y matches TRUTH_TABLE bit-for-bit. Repeat with TRUTH_TABLE=8'hA5.
- Reset, then en=1 with abc=100 for one edge → y_q=1, valid_q=1, hit_count=1. Next edge with en=0 → valid_q=0, y_q holds at 1.
- CNT_W=3, en=1, abc=000 for 10 edges → hit_count climbs to 7 and holds at 7. Then clr=1 with a capture in the same edge → hit_count=0.
- hit_count=5, pulse reset_n low between clock edges → y_q, valid_q and hit_count become 0 immediately, while y still tracks abc.
